audio_adc_rx: RTL

Serial audio receiver for the WM8731 codec ADC path. It is the capture-side counterpart of the DAC serializer in `music_statemachine`. It oversamples `AUD_BCLK`, `AUD_ADCLRCK` and `AUD_ADCDAT` in the 50 MHz system domain and deserializes I2S-format stereo words. It then presents each left/right sample pair to downstream logic (game input detection, scoring) over a ready/valid handshake.

---
 rtl/audio_rx_pkg.sv | 20 ++
 rtl/audio_edge_sync.sv | 44 ++++
 rtl/audio_adc_rx.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_rx_pkg.sv
// audio_rx_pkg: shared types and constants for the WM8731 ADC receive path.
package audio_rx_pkg;

  // Deserializer states: hunt for frame start, skip the I2S delay bit,
  // shift data bits, then idle until the word clock toggles.
  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    FULL  = 2'd3
  } rx_state_e;

  // Default channel word width.
  localparam int SAMPLE_WIDTH_DEF = 16;

  // Shortest BCLK high/low phase, in system clock cycles, that the
  // synchronizers and edge detectors can resolve reliably.
  localparam int MIN_BCLK_PHASE = 3;

endpackage

// File: rtl/audio_edge_sync.sv
// audio_edge_sync: multi-flop synchronizer for one asynchronous codec line,
// followed by a one-flop edge detector with registered rise/fall pulses.
// level_o is taken from the detector flop so that it lines up with the
// pulses; a data line passed through a sibling instance is therefore
// sampled at the same point as the clock line's edge pulse.
module audio_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;
  logic              sync_out_s;

  assign sync_out_s = sync_q[STAGES-1];

  // Synchronizer chain, previous-value flop and registered edge pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_out_s;
      rise_q <= sync_out_s & ~prev_q;
      fall_q <= ~sync_out_s & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S stereo capture from the WM8731 ADC path. Oversamples
// BCLK/ADCLRCK/ADCDAT in the system clock domain, deserializes left/right
// words and presents each pair over a ready/valid handshake with a sticky
// overrun flag. Optional feature macro: AUDIO_RX_PEAK_EN adds per-channel
// absolute peak registers (peak_left/peak_right) and the peak_clear input.
module audio_adc_rx
  import audio_rx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    AUD_BCLK,
  input  logic                    AUD_ADCLRCK,
  input  logic                    AUD_ADCDAT,
  input  logic                    enable,
  input  logic                    sample_ready,
  input  logic                    clear_overrun,
`ifdef AUDIO_RX_PEAK_EN
  input  logic                    peak_clear,
  output logic [SAMPLE_WIDTH-2:0] peak_left,
  output logic [SAMPLE_WIDTH-2:0] peak_right,
`endif
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);

  // Conditioned codec lines.
  logic bclk_rise_s;
  logic bclk_fall_unused;
  logic bclk_level_unused;
  logic lr_rise_s;
  logic lr_fall_s;
  logic lr_level_unused;
  logic dat_s;
  logic dat_rise_unused;
  logic dat_fall_unused;
  logic lr_edge_s;

  audio_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .d_i    (AUD_BCLK),
    .level_o(bclk_level_unused),
    .rise_o (bclk_rise_s),
    .fall_o (bclk_fall_unused)
  );

  audio_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .d_i    (AUD_ADCLRCK),
    .level_o(lr_level_unused),
    .rise_o (lr_rise_s),
    .fall_o (lr_fall_s)
  );

  audio_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .d_i    (AUD_ADCDAT),
    .level_o(dat_s),
    .rise_o (dat_rise_unused),
    .fall_o (dat_fall_unused)
  );

  assign lr_edge_s = lr_rise_s | lr_fall_s;

  // Deserializer state.
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] word_q, word_d;
  logic [SAMPLE_WIDTH-1:0] aligned_word_s;
  logic              commit_left_s;
  logic              commit_pair_s;

  // Received bits sit in the LSBs; shifting by the missing bit count
  // left-aligns a short word and zero-fills its unreceived LSBs.
  assign aligned_word_s = word_q << (CNT_W'(SAMPLE_WIDTH) - cnt_q);

  // Next-state logic: frame alignment, bit shifting and word commit strobes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    commit_left_s = 1'b0;
    commit_pair_s = 1'b0;
    if (!enable) begin
      state_d = ALIGN;
      cnt_d   = '0;
      word_d  = '0;
    end else begin
      case (state_q)
        ALIGN: begin
          if (lr_fall_s) begin
            state_d = SKIP;
          end else begin
            state_d = ALIGN;
          end
        end
        SKIP: begin
          if (lr_edge_s) begin
            // A word clock edge with no data bits means we lost the frame.
            state_d = ALIGN;
          end else if (bclk_rise_s) begin
            state_d = SHIFT;
            cnt_d   = '0;
            word_d  = '0;
          end else begin
            state_d = SKIP;
          end
        end
        SHIFT, FULL: begin
          if (lr_edge_s) begin
            commit_left_s = lr_rise_s;
            commit_pair_s = lr_fall_s;
            state_d       = SKIP;
          end else if (bclk_rise_s && (state_q == SHIFT)) begin
            word_d = {word_q[SAMPLE_WIDTH-2:0], dat_s};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SAMPLE_WIDTH - 1)) begin
              state_d = FULL;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ALIGN;
        end
      endcase
    end
  end

  // Deserializer registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ALIGN;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // Pair holding and handshake.
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    load_s;
  logic                    drop_s;

  // A completed pair loads when the slot is free or is being emptied now.
  assign load_s = commit_pair_s & (~valid_q | sample_ready);
  assign drop_s = commit_pair_s & valid_q & ~sample_ready;

  // Output pair, valid and sticky overrun next-state.
  always_comb begin
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    if (commit_left_s) begin
      left_hold_d = aligned_word_s;
    end else begin
      left_hold_d = left_hold_q;
    end
    if (load_s) begin
      left_d  = left_hold_q;
      right_d = aligned_word_s;
      valid_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Output pair registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

`ifdef AUDIO_RX_PEAK_EN
  // Magnitude of a two's complement word; the most-negative code has no
  // positive counterpart and saturates to the largest magnitude.
  function automatic logic [SAMPLE_WIDTH-2:0] abs_sat(input logic [SAMPLE_WIDTH-1:0] v);
    logic [SAMPLE_WIDTH-1:0] neg;
    neg = ~v + {{(SAMPLE_WIDTH-1){1'b0}}, 1'b1};
    if (!v[SAMPLE_WIDTH-1]) begin
      abs_sat = v[SAMPLE_WIDTH-2:0];
    end else if (neg[SAMPLE_WIDTH-1]) begin
      abs_sat = '1;
    end else begin
      abs_sat = neg[SAMPLE_WIDTH-2:0];
    end
  endfunction

  logic [SAMPLE_WIDTH-2:0] peak_l_q, peak_l_d;
  logic [SAMPLE_WIDTH-2:0] peak_r_q, peak_r_d;
  logic [SAMPLE_WIDTH-2:0] mag_l_s;
  logic [SAMPLE_WIDTH-2:0] mag_r_s;

  assign mag_l_s = abs_sat(left_hold_q);
  assign mag_r_s = abs_sat(aligned_word_s);

  // Peak max-accumulation on each pair load; clear takes priority.
  always_comb begin
    peak_l_d = peak_l_q;
    peak_r_d = peak_r_q;
    if (peak_clear) begin
      peak_l_d = '0;
      peak_r_d = '0;
    end else if (load_s) begin
      peak_l_d = (mag_l_s > peak_l_q) ? mag_l_s : peak_l_q;
      peak_r_d = (mag_r_s > peak_r_q) ? mag_r_s : peak_r_q;
    end else begin
      peak_l_d = peak_l_q;
      peak_r_d = peak_r_q;
    end
  end

  // Peak registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign peak_left  = peak_l_q;
  assign peak_right = peak_r_q;
`endif

endmodule
